// File: rtl/motor_ctrl_pkg.sv
// Shared types and defaults for the closed-loop motor speed controller.
// Also provides the saturation helper used when a speed window closes.
package motor_ctrl_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STALL} state_t;

   typedef logic signed [15:0] speed_t;

   localparam int DEF_PWM_PERIOD = 2500;
   localparam int DEF_SAMPLE_DIV = 50000;

   // Clamp the 17-bit window count into the symmetric 16-bit speed range.
   function automatic speed_t sat_speed(input logic signed [16:0] acc);
      if (acc > 17'sd32767)
         return 16'sh7fff;
      else if (acc < -17'sd32767)
         return -16'sd32767;
      return acc[15:0];
   endfunction

endpackage

// File: rtl/motor_speed_ctrl_if.sv
// Software-facing setpoint handshake and speed/fault readback bundle.
interface motor_speed_ctrl_if;
   import motor_ctrl_pkg::*;

   logic   sp_valid;
   logic   sp_ready;
   speed_t sp_data;
   speed_t speed;
   logic   fault;

   modport master (output sp_valid, sp_data, input sp_ready, speed, fault);
   modport slave  (input sp_valid, sp_data, output sp_ready, speed, fault);

endinterface

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: two-flop synchronizers plus Gray-step decode.
// step pulses for one clk per valid single-phase change; dir = 1 when A leads.
module quad_decoder (
   input  logic clk,
   input  logic reset_n,
   input  logic enc_a,
   input  logic enc_b,
   output logic step,
   output logic dir
);

   logic [1:0] r_sync_a;
   logic [1:0] r_sync_b;
   logic       r_prev_a;
   logic       r_prev_b;

   // NOTE: non-blocking assignments keep the shift chain a true two-stage delay.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync_a <= '0;
         r_sync_b <= '0;
         r_prev_a <= 1'b0;
         r_prev_b <= 1'b0;
      end else begin
         r_sync_a <= {r_sync_a[0], enc_a};
         r_sync_b <= {r_sync_b[0], enc_b};
         r_prev_a <= r_sync_a[1];
         r_prev_b <= r_sync_b[1];
      end
   end

   // Exactly one phase changed; a simultaneous change cancels out.
   assign step = (r_sync_a[1] ^ r_prev_a) ^ (r_sync_b[1] ^ r_prev_b);
   assign dir  = r_sync_a[1] ^ r_prev_b;

endmodule

// File: rtl/motor_speed_ctrl.sv
// Encoder speed measurement, incremental P loop and two-line PWM drive.
// Stall detection is built only when MOTOR_STALL_DETECT_EN is defined.
module motor_speed_ctrl
   import motor_ctrl_pkg::*;
#(
   parameter int PWM_PERIOD = DEF_PWM_PERIOD,
   parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
   parameter int DUTY_W     = 12,
   parameter int KP_SHIFT   = 4
`ifdef MOTOR_STALL_DETECT_EN
   ,
   parameter int STALL_SAMPLES = 8
`endif
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                enc_a,
   input  logic                enc_b,
   motor_speed_ctrl_if.slave   sp_if,
   output logic [1:0]          pwm_out
);

   localparam int CMD_W  = DUTY_W + 1;
   localparam int DIV_W  = $clog2(SAMPLE_DIV);
   localparam int PWM_CW = $clog2(PWM_PERIOD);

   typedef logic signed [CMD_W-1:0] cmd_t;

   logic                    w_step, w_dir, w_tick, w_pwm_wrap, w_cmd_sign;
   logic [DIV_W-1:0]        r_div_cnt;
   logic                    r_tick_d;
   logic signed [16:0]      r_acc, w_step_val, w_err, w_err_sh;
   speed_t                  r_speed, r_sp;
   logic                    r_sp_ready;
   state_t                  r_state;
   cmd_t                    r_cmd, w_cmd_next;
   int                      w_sum;
   logic [CMD_W-1:0]        w_cmd_abs, r_duty;
   logic [PWM_CW-1:0]       r_pwm_cnt;
   logic                    r_dir, r_dead;
   logic [1:0]              r_pwm_out, w_pwm_drive;

   quad_decoder u_quad (
      .clk     (clk),
      .reset_n (reset_n),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .step    (w_step),
      .dir     (w_dir)
   );

   assign w_tick     = (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));
   assign w_step_val = w_step ? (w_dir ? 17'sd1 : -17'sd1) : 17'sd0;

   // A step landing in the tick cycle seeds the new window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div_cnt <= '0;
         r_tick_d  <= 1'b0;
         r_acc     <= '0;
         r_speed   <= '0;
         r_sp      <= '0;
      end else begin
         r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
         r_tick_d  <= w_tick;
         if (w_tick) begin
            r_speed <= sat_speed(r_acc);
            r_acc   <= w_step_val;
         end else begin
            r_acc <= r_acc + w_step_val;
         end
         if (sp_if.sp_valid && r_sp_ready)
            r_sp <= sp_if.sp_data;
      end
   end

   assign w_err      = {r_sp[15], r_sp} - {r_speed[15], r_speed};
   assign w_err_sh   = w_err >>> KP_SHIFT;
   assign w_sum      = int'(r_cmd) + int'(w_err_sh);
   assign w_cmd_sign = r_cmd[CMD_W-1];
   assign w_cmd_abs  = w_cmd_sign ? CMD_W'(-r_cmd) : CMD_W'(r_cmd);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_cmd_next = cmd_t'(w_sum);
      if (w_sum > PWM_PERIOD)
         w_cmd_next = cmd_t'(PWM_PERIOD);
      else if (w_sum < -PWM_PERIOD)
         w_cmd_next = cmd_t'(-PWM_PERIOD);
   end

`ifdef MOTOR_STALL_DETECT_EN
   localparam int STALL_CW = $clog2(STALL_SAMPLES + 1);
   logic [STALL_CW-1:0] r_stall_cnt;
   logic                r_fault;
   logic                w_stalled;

   assign w_stalled   = (w_cmd_abs == CMD_W'(PWM_PERIOD)) && (r_speed == '0);
   assign sp_if.fault = r_fault;
`else
   assign sp_if.fault = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cmd      <= '0;
         r_sp_ready <= 1'b0;
`ifdef MOTOR_STALL_DETECT_EN
         r_stall_cnt <= '0;
         r_fault     <= 1'b0;
`endif
      end else begin
         r_sp_ready <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               r_cmd <= '0;
               if (enable)
                  r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (!enable) begin
                  r_state <= ST_IDLE;
                  r_cmd   <= '0;
`ifdef MOTOR_STALL_DETECT_EN
                  r_stall_cnt <= '0;
`endif
               end else if (r_tick_d) begin
                  r_cmd <= w_cmd_next;
`ifdef MOTOR_STALL_DETECT_EN
                  if (!w_stalled) begin
                     r_stall_cnt <= '0;
                  end else if (r_stall_cnt == STALL_CW'(STALL_SAMPLES - 1)) begin
                     r_state     <= ST_STALL;
                     r_cmd       <= '0;
                     r_fault     <= 1'b1;
                     r_sp_ready  <= 1'b0;
                     r_stall_cnt <= '0;
                  end else begin
                     r_stall_cnt <= r_stall_cnt + STALL_CW'(1);
                  end
`endif
               end
            end
            ST_STALL: begin
               r_cmd <= '0;
               if (!enable) begin
                  r_state <= ST_IDLE;
`ifdef MOTOR_STALL_DETECT_EN
                  r_fault <= 1'b0;
`endif
               end else begin
                  r_sp_ready <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_pwm_wrap = (r_pwm_cnt == PWM_CW'(PWM_PERIOD - 1));

   always_comb begin
      w_pwm_drive = 2'b00;
      if (enable && r_state == ST_RUN && !r_dead && CMD_W'(r_pwm_cnt) < r_duty)
         w_pwm_drive = r_dir ? 2'b10 : 2'b01;
   end

   // A nonzero command of opposite sign buys one fully-off period first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm_cnt <= '0;
         r_duty    <= '0;
         r_dir     <= 1'b0;
         r_dead    <= 1'b0;
         r_pwm_out <= 2'b00;
      end else begin
         if (w_pwm_wrap) begin
            r_pwm_cnt <= '0;
            r_duty    <= w_cmd_abs;
            if (w_cmd_abs != '0 && w_cmd_sign != r_dir) begin
               r_dir  <= w_cmd_sign;
               r_dead <= 1'b1;
            end else begin
               r_dead <= 1'b0;
            end
         end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_CW'(1);
         end
         r_pwm_out <= w_pwm_drive;
      end
   end

   assign sp_if.sp_ready = r_sp_ready;
   assign sp_if.speed    = r_speed;
   assign pwm_out        = r_pwm_out;

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Directed bench for motor_speed_ctrl with PWM_PERIOD=100 and SAMPLE_DIV=1000.
// Cycle numbers count posedges since the last reset release.
module tb_motor_speed_ctrl;
   import motor_ctrl_pkg::*;

   localparam int PWM = 100;
   localparam int DIV = 1000;

   typedef struct {
      int sp;
      int acc_edge;
      int exp_fwd;
      int exp_rev;
   } vec_t;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b1;
   logic       enable  = 1'b0;
   logic       enc_a   = 1'b0;
   logic       enc_b   = 1'b0;
   logic [1:0] pwm_out;

   int checks   = 0;
   int failures = 0;
   int cyc;
   int f_cnt, r_cnt;
   vec_t vecs[9];

   motor_speed_ctrl_if bus ();

   motor_speed_ctrl #(
      .PWM_PERIOD (PWM),
      .SAMPLE_DIV (DIV),
      .DUTY_W     (12),
      .KP_SHIFT   (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .sp_if   (bus.slave),
      .pwm_out (pwm_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      enable       = 1'b0;
      bus.sp_valid = 1'b0;
      bus.sp_data  = '0;
      enc_a        = 1'b0;
      enc_b        = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Offer a setpoint so that the accepting clk edge is edge_n.
   task automatic put_sp(input int edge_n, input int val);
      wait_cyc(edge_n - 1);
      bus.sp_valid = 1'b1;
      bus.sp_data  = speed_t'(val);
      check("sp_ready_at_offer", int'(bus.sp_ready), 1);
      @(negedge clk);
      bus.sp_valid = 1'b0;
   endtask

   task automatic measure(input int first, input int last, output int fwd, output int rev);
      fwd = 0;
      rev = 0;
      wait_cyc(first);
      for (int i = first; i <= last; i++) begin
         if (pwm_out[0]) fwd++;
         if (pwm_out[1]) rev++;
         @(negedge clk);
      end
   endtask

   task automatic enc_fwd();
      if (enc_a == enc_b) enc_a = ~enc_a;
      else                enc_b = ~enc_b;
      repeat (3) @(negedge clk);
   endtask

   task automatic enc_rev();
      if (enc_a == enc_b) enc_b = ~enc_b;
      else                enc_a = ~enc_a;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // {setpoint, accepting edge, fwd highs, rev highs} over edges 1201..1300
      vecs[0] = '{64,     5,    4,   0};
      vecs[1] = '{-64,    5,    0,   4};
      vecs[2] = '{17,     5,    1,   0};
      vecs[3] = '{15,     5,    0,   0};
      vecs[4] = '{-1,     5,    0,   1};
      vecs[5] = '{-17,    5,    0,   2};
      vecs[6] = '{64,     1000, 4,   0};
      vecs[7] = '{64,     1001, 0,   0};
      vecs[8] = '{32767,  5,    100, 0};

      // Reset with encoder activity and a setpoint offered.
      #2;
      reset_n      = 1'b0;
      bus.sp_valid = 1'b1;
      bus.sp_data  = 16'sd100;
      for (int i = 0; i < 4; i++) begin
         enc_a = ~enc_a;
         if (i % 2 == 1) enc_b = ~enc_b;
         @(negedge clk);
         check("reset_pwm", int'(pwm_out), 0);
      end
      check("reset_speed", int'(bus.speed), 0);
      check("reset_fault", int'(bus.fault), 0);
      check("reset_sp_ready", int'(bus.sp_ready), 0);
      enc_a = 1'b0;
      enc_b = 1'b0;
      reset_n = 1'b1;
      #1;
      check("sp_ready_at_release", int'(bus.sp_ready), 0);
      @(negedge clk);
      check("sp_ready_1clk_after", int'(bus.sp_ready), 1);
      bus.sp_valid = 1'b0;

      // Encoder windows.
      wait_cyc(10);
      for (int i = 0; i < 100; i++) enc_fwd();
      wait_cyc(999);
      check("speed_before_tick", int'(bus.speed), 0);
      wait_cyc(1000);
      check("speed_fwd_100", int'(bus.speed), 100);
      wait_cyc(1010);
      for (int i = 0; i < 40; i++) enc_rev();
      wait_cyc(2000);
      check("speed_rev_40", int'(bus.speed), -40);
      wait_cyc(2100);
      enc_a = ~enc_a;
      enc_b = ~enc_b;
      wait_cyc(2997);
      enc_fwd();
      wait_cyc(3000);
      check("speed_double_change", int'(bus.speed), 0);
      wait_cyc(4000);
      check("speed_tick_step_new_window", int'(bus.speed), 1);

      // Table: setpoint response, rounding and handshake timing.
      for (int i = 0; i < 9; i++) begin
         do_reset();
         enable = 1'b1;
         put_sp(vecs[i].acc_edge, vecs[i].sp);
         measure(1201, 1300, f_cnt, r_cnt);
         check($sformatf("vec%0d_fwd", i), f_cnt, vecs[i].exp_fwd);
         check($sformatf("vec%0d_rev", i), r_cnt, vecs[i].exp_rev);
      end
      check("full_duty_hold", int'(pwm_out), 1);
      reset_n = 1'b0;
      #1;
      check("reset_async_pwm", int'(pwm_out), 0);
      check("reset_async_ready", int'(bus.sp_ready), 0);

      // Direction reversal: +4 -> -59 (floor of -62.5 is -63).
      do_reset();
      enable = 1'b1;
      put_sp(5, 64);
      put_sp(1300, -1000);
      measure(2001, 2100, f_cnt, r_cnt);
      check("rev_old_fwd", f_cnt, 4);
      check("rev_old_rev", r_cnt, 0);
      measure(2101, 2200, f_cnt, r_cnt);
      check("dead_period", f_cnt + r_cnt, 0);
      measure(2201, 2300, f_cnt, r_cnt);
      check("rev_new_fwd", f_cnt, 0);
      check("rev_new_rev", r_cnt, 59);
      wait_cyc(2310);
      check("mid_pulse_rev", int'(pwm_out), 2);
      enable = 1'b0;
      @(negedge clk);
      check("enable_drop_pwm", int'(pwm_out), 0);

      // Full command with no motion.
      do_reset();
      enable = 1'b1;
      put_sp(5, 32767);
      wait_cyc(8990);
      check("stall_pre_pwm", int'(pwm_out), 1);
      check("stall_pre_fault", int'(bus.fault), 0);
      wait_cyc(9010);
`ifdef MOTOR_STALL_DETECT_EN
      check("stall_fault", int'(bus.fault), 1);
      check("stall_pwm", int'(pwm_out), 0);
      check("stall_sp_ready", int'(bus.sp_ready), 0);
`else
      check("nostall_fault", int'(bus.fault), 0);
      check("nostall_pwm", int'(pwm_out), 1);
      check("nostall_sp_ready", int'(bus.sp_ready), 1);
`endif
      enable = 1'b0;
      wait_cyc(9013);
      check("idle_fault", int'(bus.fault), 0);
      check("idle_sp_ready", int'(bus.sp_ready), 1);
      check("idle_pwm", int'(pwm_out), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/motor_speed_ctrl.md
# motor_speed_ctrl

Closed-loop DC motor speed controller between the board GPIO and the Nios software. It decodes the quadrature encoder inputs, measures speed once per sample period, and runs an incremental proportional loop toward a software-supplied setpoint. It drives a two-line PWM output: forward on one line, reverse on the other. Software writes setpoints through a valid/ready handshake and reads back the measured speed and the fault flag.

## Interface
- `PWM_PERIOD`, 2500: PWM period in clk cycles (20 kHz at 50 MHz).
- `SAMPLE_DIV`, 50000: clk cycles per speed sample (1 kHz).
- `DUTY_W`, 12: duty magnitude width; must satisfy 2^DUTY_W > PWM_PERIOD.
- `KP_SHIFT`, 4: proportional gain expressed as a right shift of the error.
- `STALL_SAMPLES`, 8: consecutive stalled samples before a fault.
- `clk`  in  1  system clock (50 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  loop enable; low forces IDLE.
- `enc_a`, `enc_b`  in  1 each  raw asynchronous encoder phases.
- `sp_valid`  in  1  setpoint offered.
- `sp_ready`  out  1  setpoint can be accepted.
- `sp_data`  in  16  signed target speed, in encoder counts per sample.
- `speed`  out  16  signed measured counts in the last sample window.
- `pwm_out`  out  2  [0] forward PWM, [1] reverse PWM.
- `fault`  out  1  stall fault latched.

## Operation
- Encoder path:
  - Each phase passes through a 2-flop synchronizer, then a quadrature decode.
  - A valid Gray step adds +1 (A leads) or -1 (B leads) to a signed 17-bit window accumulator.
  - A step where both phases change at once is ignored.
- Sample tick: a divider counts 0..SAMPLE_DIV-1 and pulses `tick` on wrap.
  - On tick, `speed` <= the accumulator saturated to ±32767, and the accumulator restarts.
  - An encoder step in the tick cycle is counted in the new window.
- Setpoint: the handshake completes when `sp_valid && sp_ready`.
  - The accepted value goes into a holding register and is used at the next control update.
  - `sp_ready` is 1 in IDLE and RUN, and 0 in STALL and during reset.
- Control update, one cycle after tick:
  - err = sp - speed, 17-bit signed.
  - cmd <= sat(cmd + (err >>> KP_SHIFT)), clamped to ±PWM_PERIOD.
  - The arithmetic shift rounds toward negative infinity.
- PWM generator:
  - A counter runs 0..PWM_PERIOD-1.
  - Shadow duty and direction load from cmd only at wrap (counter == PWM_PERIOD-1).
  - The active line is high while counter < |duty|; the other line is held 0.
  - |duty| = 0 gives both lines low; |duty| = PWM_PERIOD gives the active line constantly high.
  - When the sign of the newly loaded cmd differs from the current direction and |cmd| ≠ 0, one full PWM period is inserted with both lines low before the new direction drives.
- State machine:
  - IDLE: cmd = 0, pwm_out = 0. Goes to RUN when `enable` = 1.
  - RUN: loop active. Goes to IDLE on `enable` = 0. Goes to STALL on the stall condition.
  - STALL: pwm_out = 0, fault = 1, cmd cleared. Goes to IDLE only when `enable` = 0.
- Stall condition: |cmd| == PWM_PERIOD and speed == 0 on STALL_SAMPLES consecutive ticks.
  - Any tick that breaks the condition clears the stall counter.
- `enable` deasserted mid-period: pwm_out goes to 0 on the next clock with no wait for wrap. The PWM counter keeps running.

## Timing
- Every output is registered.
- Reset values: sp_ready = 0, speed = 0, pwm_out = 2'b00, fault = 0, state = IDLE, every counter and accumulator = 0, holding setpoint = 0.
- sp_ready rises on the first clk after reset_n is released.
- Encoder latency: pin edge to accumulator update takes 3 clks (2 sync stages + 1 decode register).
- Tick at cycle T: `speed` valid at T+1, cmd at T+2, applied at the first PWM wrap after T+2.
- Setpoint accepted in the tick cycle: used in that tick's update.
- Setpoint accepted in the T+1 cycle: deferred to the next tick.
- Reset asserted mid-operation clears everything asynchronously. PWM lines drop immediately.

## Configuration
- `MOTOR_STALL_DETECT_EN` defined: stall counter, STALL state and `fault` are present as described above.
- Not defined:
  - `fault` is tied to 0.
  - STALL is unreachable and no stall counter is synthesized.
  - `sp_ready` is 1 whenever out of reset.

## Structure
- Package `motor_ctrl_pkg`:
  - state enum (IDLE, RUN, STALL);
  - the 16-bit speed/setpoint type;
  - default PWM_PERIOD and SAMPLE_DIV constants.
- Sub-module `quad_decoder`: synchronizers plus step decode. Outputs are `step` and `dir` pulses.
- PWM, divider, loop and FSM live in `motor_speed_ctrl`.

## Test plan
- Reset with enc toggling and sp_valid = 1 → all outputs 0 during reset; sp_ready = 1 one clk after release.
- SAMPLE_DIV = 1000: 100 forward quadrature steps within a window → speed = +100; 40 reverse steps → speed = -40. A simultaneous A/B change → no count.
- PWM_PERIOD = 100, enable = 1, sp = 64, speed 0 → cmd = +4 after the first tick. From the next wrap, pwm_out[0] is high 4 cycles of every 100 and pwm_out[1] = 0.
- Drive cmd from +4 to negative → exactly one 100-cycle period with pwm_out = 00, then pwm_out[1] pulses.
- sp = 32767, no encoder motion, macro defined, STALL_SAMPLES = 8 → cmd clamps at 100 with pwm_out[0] constantly high. After 8 stalled ticks: fault = 1, pwm_out = 00, sp_ready = 0. Dropping `enable` → IDLE with fault cleared.
- Deassert `enable` mid-pulse → pwm_out = 00 on the next clk.
